// File: rtl/trace_pkg.sv
// Shared types for the commit-side trace scheduler: default widths,
// the trace entry layout and the queue-occupancy state encoding.
package trace_pkg;

  localparam int unsigned TRACE_PC_W   = 32;
  localparam int unsigned TRACE_DATA_W = 32;
  localparam int unsigned TRACE_REG_W  = 5;
  localparam int unsigned TRACE_CNT_W  = 32;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]   pc;
    logic [TRACE_DATA_W-1:0] wdata;
    logic [TRACE_REG_W-1:0]  wnum;
  } trace_entry_t;

  // State doubles as the queue occupancy (0, 1 or 2 entries held).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/trace_slot_qualify.sv
// Per-slot commit filter: a slot reaches the trace only if it is valid and
// writes a register. Build option TRACE_FILTER_R0_EN also drops writes to r0.
module trace_slot_qualify #(
  parameter int REG_W = 5
) (
  input  logic             valid,
  input  logic             wen,
  input  logic [REG_W-1:0] wnum,
  output logic             qual
);

`ifdef TRACE_FILTER_R0_EN
  assign qual = valid & wen & (wnum != '0);
`else
  logic unused_wnum;
  assign unused_wnum = ^wnum;
  assign qual        = valid & wen;
`endif

endmodule

// File: rtl/trace_commit_sched.sv
// Merges the two writeback commit slots into one in-order trace entry per
// cycle through a 2-entry queue, stalling the core when the queue is full.
// Optional build macro: TRACE_FILTER_R0_EN (drop commits that write r0).
module trace_commit_sched
  import trace_pkg::*;
#(
  parameter int PC_W   = TRACE_PC_W,
  parameter int DATA_W = TRACE_DATA_W,
  parameter int REG_W  = TRACE_REG_W,
  parameter int CNT_W  = TRACE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmt0_valid,
  input  logic              cmt0_wen,
  input  logic [PC_W-1:0]   cmt0_pc,
  input  logic [REG_W-1:0]  cmt0_wnum,
  input  logic [DATA_W-1:0] cmt0_wdata,
  input  logic              cmt1_valid,
  input  logic              cmt1_wen,
  input  logic [PC_W-1:0]   cmt1_pc,
  input  logic [REG_W-1:0]  cmt1_wnum,
  input  logic [DATA_W-1:0] cmt1_wdata,
  output logic              cmt_ready,
  output logic              cmt_stall,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [PC_W-1:0]   tr_pc,
  output logic [REG_W-1:0]  tr_wnum,
  output logic [DATA_W-1:0] tr_wdata,
  output logic [3:0]        tr_wen,
  output logic [CNT_W-1:0]  emit_cnt
);

  // Same field order as trace_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  wnum;
  } entry_t;

  sched_state_e     state_q, state_d;
  entry_t           q0_q, q0_d, q1_q, q1_d;
  logic [CNT_W-1:0] emit_cnt_q, emit_cnt_d;

  logic       qual0, qual1;
  logic [1:0] n_qual;
  logic       pop;
  entry_t     slot0, slot1, first_e, second_e;

  trace_slot_qualify #(.REG_W(REG_W)) u_qual0 (
    .valid (cmt0_valid),
    .wen   (cmt0_wen),
    .wnum  (cmt0_wnum),
    .qual  (qual0)
  );

  trace_slot_qualify #(.REG_W(REG_W)) u_qual1 (
    .valid (cmt1_valid),
    .wen   (cmt1_wen),
    .wnum  (cmt1_wnum),
    .qual  (qual1)
  );

  assign slot0 = '{pc: cmt0_pc, wdata: cmt0_wdata, wnum: cmt0_wnum};
  assign slot1 = '{pc: cmt1_pc, wdata: cmt1_wdata, wnum: cmt1_wnum};

  // Compact qualified slots so the older one always lands at the head.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    n_qual   = {1'b0, qual0} + {1'b0, qual1};
    first_e  = qual0 ? slot0 : slot1;
    second_e = slot1;
  end

  assign pop = tr_valid & tr_ready;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        case (n_qual)
          2'd0:    state_d = EMPTY;
          2'd1:    state_d = ONE;
          default: state_d = TWO;
        endcase
      end
      ONE: begin
        if (pop) begin
          case (n_qual)
            2'd0:    state_d = EMPTY;
            2'd1:    state_d = ONE;
            default: state_d = TWO;
          endcase
        end
      end
      TWO:     state_d = pop ? ONE : TWO;
      default: state_d = EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    cmt_ready = ~reset & ((state_q == EMPTY) | ((state_q == ONE) & tr_ready));
    tr_valid  = (state_q != EMPTY);
    tr_pc     = '0;
    tr_wnum   = '0;
    tr_wdata  = '0;
    tr_wen    = 4'h0;
    if (tr_valid) begin
      tr_pc    = q0_q.pc;
      tr_wnum  = q0_q.wnum;
      tr_wdata = q0_q.wdata;
      tr_wen   = 4'hF;
    end
  end

  assign cmt_stall = ~cmt_ready;

  // Accept only happens when the queue is empty after this cycle's pop,
  // so new entries always load from the head.
  always_comb begin
    q0_d = q0_q;
    q1_d = q1_q;
    if (cmt_ready) begin
      q0_d = first_e;
      q1_d = second_e;
    end else if (pop) begin
      q0_d = q1_q;
    end
  end

  // NOTE: queue payload is not reset; outputs are gated by state, so stale data never escapes.
  always_ff @(posedge clk) begin
    q0_q <= q0_d;
    q1_q <= q1_d;
  end

  assign emit_cnt_d = emit_cnt_q + CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      emit_cnt_q <= '0;
    end else begin
      emit_cnt_q <= emit_cnt_d;
    end
  end

  assign emit_cnt = emit_cnt_q;

endmodule

// File: tb/tb_trace_commit_sched.sv
// Directed vector table plus a randomized scoreboard run for trace_commit_sched.
module tb_trace_commit_sched;
  import trace_pkg::*;

`ifdef TRACE_FILTER_R0_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmt0_valid, cmt0_wen, cmt1_valid, cmt1_wen;
  logic [31:0] cmt0_pc, cmt0_wdata, cmt1_pc, cmt1_wdata;
  logic [4:0]  cmt0_wnum, cmt1_wnum;
  logic        cmt_ready, cmt_stall, tr_valid, tr_ready;
  logic [31:0] tr_pc, tr_wdata, emit_cnt;
  logic [4:0]  tr_wnum;
  logic [3:0]  tr_wen;

  always #5 clk = ~clk;

  trace_commit_sched dut (
    .clk        (clk),
    .reset      (reset),
    .cmt0_valid (cmt0_valid),
    .cmt0_wen   (cmt0_wen),
    .cmt0_pc    (cmt0_pc),
    .cmt0_wnum  (cmt0_wnum),
    .cmt0_wdata (cmt0_wdata),
    .cmt1_valid (cmt1_valid),
    .cmt1_wen   (cmt1_wen),
    .cmt1_pc    (cmt1_pc),
    .cmt1_wnum  (cmt1_wnum),
    .cmt1_wdata (cmt1_wdata),
    .cmt_ready  (cmt_ready),
    .cmt_stall  (cmt_stall),
    .tr_valid   (tr_valid),
    .tr_ready   (tr_ready),
    .tr_pc      (tr_pc),
    .tr_wnum    (tr_wnum),
    .tr_wdata   (tr_wdata),
    .tr_wen     (tr_wen),
    .emit_cnt   (emit_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          v0, w0;
    logic [31:0] pc0;
    logic [4:0]  n0;
    logic [31:0] d0;
    bit          v1, w1;
    logic [31:0] pc1;
    logic [4:0]  n1;
    logic [31:0] d1;
    bit          rdy;
    bit          e_ready;   // cmt_ready before the edge
    bit          e_valid;   // registered outputs after the edge
    logic [31:0] e_pc;
    logic [4:0]  e_wnum;
    logic [31:0] e_wdata;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(
      bit rst, bit v0, bit w0, logic [31:0] pc0, logic [4:0] n0, logic [31:0] d0,
      bit v1, bit w1, logic [31:0] pc1, logic [4:0] n1, logic [31:0] d1,
      bit rdy, bit er, bit ev, logic [31:0] ep, logic [4:0] en, logic [31:0] ed, logic [31:0] ec);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.w0 = w0; v.pc0 = pc0; v.n0 = n0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.pc1 = pc1; v.n1 = n1; v.d1 = d1; v.rdy = rdy;
    v.e_ready = er; v.e_valid = ev; v.e_pc = ep; v.e_wnum = en; v.e_wdata = ed; v.e_cnt = ec;
    return v;
  endfunction

  vec_t vt[$];

  task automatic drive(input vec_t v);
    reset = v.rst;
    cmt0_valid = v.v0; cmt0_wen = v.w0; cmt0_pc = v.pc0; cmt0_wnum = v.n0; cmt0_wdata = v.d0;
    cmt1_valid = v.v1; cmt1_wen = v.w1; cmt1_pc = v.pc1; cmt1_wnum = v.n1; cmt1_wdata = v.d1;
    tr_ready = v.rdy;
  endtask

  // Scoreboard state for the randomized run
  trace_entry_t exp_q[$];
  int           qual_total = 0;

  task automatic sb_cycle();
    trace_entry_t e;
    @(negedge clk);
    check("rand_stall", {63'd0, cmt_stall}, {63'd0, ~cmt_ready});
    if (tr_valid && tr_ready) begin
      if (exp_q.size() == 0) begin
        check("rand_spurious_pop", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rand_pc", {32'd0, tr_pc}, {32'd0, e.pc});
        check("rand_wnum_wdata", {27'd0, tr_wnum, tr_wdata}, {27'd0, e.wnum, e.wdata});
        check("rand_wen", {60'd0, tr_wen}, 64'hF);
      end
    end
    if (cmt_ready) begin
      if (cmt0_valid && cmt0_wen && (!FILT || cmt0_wnum != 5'd0)) begin
        exp_q.push_back('{pc: cmt0_pc, wdata: cmt0_wdata, wnum: cmt0_wnum});
        qual_total++;
      end
      if (cmt1_valid && cmt1_wen && (!FILT || cmt1_wnum != 5'd0)) begin
        exp_q.push_back('{pc: cmt1_pc, wdata: cmt1_wdata, wnum: cmt1_wnum});
        qual_total++;
      end
    end
  endtask

  initial begin
    logic [31:0] c18;
    logic [31:0] pc_next;
    int          pairs_done;
    int          cycles;
    bit          accepted;

    c18 = FILT ? 32'd6 : 32'd7;

    vt.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 1, 0, 0,0,0,0, 0));
    vt.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 1, 0, 0,0,0,0, 0));
    vt.push_back(mk(0, 1,1,32'hBFC00000,2,32'h1234, 0,0,0,0,0, 1, 1, 1,32'hBFC00000,2,32'h1234, 0));
    vt.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 1, 1, 0,0,0,0, 1));
    vt.push_back(mk(0, 1,1,32'h100,3,32'hAAAA, 1,1,32'h104,4,32'hBBBB, 1, 1, 1,32'h100,3,32'hAAAA, 1));
    vt.push_back(mk(0, 1,1,32'h100,3,32'hAAAA, 1,1,32'h104,4,32'hBBBB, 1, 0, 1,32'h104,4,32'hBBBB, 2));
    vt.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 1, 1, 0,0,0,0, 3));
    vt.push_back(mk(0, 1,1,32'h100,5,32'h1111, 1,1,32'h104,6,32'h2222, 0, 1, 1,32'h100,5,32'h1111, 3));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0, 1,1,32'h100,5,32'h1111, 1,1,32'h104,6,32'h2222, 0, 0, 1,32'h100,5,32'h1111, 3));
    vt.push_back(mk(0, 1,1,32'h100,5,32'h1111, 1,1,32'h104,6,32'h2222, 1, 0, 1,32'h104,6,32'h2222, 4));
    vt.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 1, 1, 0,0,0,0, 5));
    vt.push_back(mk(0, 1,0,32'h200,7,32'h3333, 1,1,32'h204,8,32'h4444, 1, 1, 1,32'h204,8,32'h4444, 5));
    vt.push_back(mk(0, 0,0,0,0,0, 1,1,32'h208,0,32'h5555, 1, 1,
                    !FILT, FILT ? 32'h0 : 32'h208, 0, FILT ? 32'h0 : 32'h5555, 6));
    vt.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 1, 1, 0,0,0,0, c18));
    vt.push_back(mk(0, 1,1,32'h300,9,32'h6666, 1,1,32'h304,10,32'h7777, 0, 1, 1,32'h300,9,32'h6666, c18));
    vt.push_back(mk(1, 1,1,32'h300,9,32'h6666, 1,1,32'h304,10,32'h7777, 0, 0, 0,0,0,0, 0));
    vt.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 1, 1, 0,0,0,0, 0));
    vt.push_back(mk(0, 1,1,32'h400,11,32'h8888, 0,0,0,0,0, 0, 1, 1,32'h400,11,32'h8888, 0));
    vt.push_back(mk(0, 1,1,32'h404,12,32'h9999, 0,0,0,0,0, 0, 0, 1,32'h400,11,32'h8888, 0));
    vt.push_back(mk(0, 1,1,32'h404,12,32'h9999, 0,0,0,0,0, 1, 1, 1,32'h404,12,32'h9999, 1));
    vt.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 1, 1, 0,0,0,0, 2));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      @(negedge clk);
      check($sformatf("v%0d_cmt_ready", i), {63'd0, cmt_ready}, {63'd0, vt[i].e_ready});
      check($sformatf("v%0d_cmt_stall", i), {63'd0, cmt_stall}, {63'd0, ~vt[i].e_ready});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_tr_valid", i), {63'd0, tr_valid}, {63'd0, vt[i].e_valid});
      check($sformatf("v%0d_tr_pc", i), {32'd0, tr_pc}, {32'd0, vt[i].e_pc});
      check($sformatf("v%0d_tr_wnum", i), {59'd0, tr_wnum}, {59'd0, vt[i].e_wnum});
      check($sformatf("v%0d_tr_wdata", i), {32'd0, tr_wdata}, {32'd0, vt[i].e_wdata});
      check($sformatf("v%0d_tr_wen", i), {60'd0, tr_wen}, vt[i].e_valid ? 64'hF : 64'h0);
      check($sformatf("v%0d_emit_cnt", i), {32'd0, emit_cnt}, {32'd0, vt[i].e_cnt});
    end

    // Randomized run: queue is empty here and emit_cnt is 2.
    pc_next    = 32'h1000_0000;
    pairs_done = 0;
    cycles     = 0;
    accepted   = 1'b1;
    while (pairs_done < 10000 && cycles < 60000) begin
      if (accepted) begin
        cmt0_valid = ($urandom_range(0, 3) != 0);
        cmt0_wen   = ($urandom_range(0, 3) != 0);
        cmt0_wnum  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        cmt0_wdata = $urandom;
        cmt0_pc    = pc_next;
        cmt1_valid = ($urandom_range(0, 3) != 0);
        cmt1_wen   = ($urandom_range(0, 3) != 0);
        cmt1_wnum  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        cmt1_wdata = $urandom;
        cmt1_pc    = pc_next + 32'd4;
        pc_next    = pc_next + 32'd8;
      end
      tr_ready = ($urandom_range(0, 3) != 0);
      sb_cycle();
      accepted = cmt_ready;
      if (accepted) pairs_done++;
      @(posedge clk);
      #1;
      cycles++;
    end
    check("rand_pairs_accepted", 64'(pairs_done), 64'd10000);

    cmt0_valid = 1'b0;
    cmt1_valid = 1'b0;
    tr_ready   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_cycle();
      @(posedge clk);
      #1;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_tr_valid", {63'd0, tr_valid}, 64'd0);
    check("rand_emit_cnt", {32'd0, emit_cnt}, {32'd0, 32'(qual_total + 2)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_commit_sched.md
# trace_commit_sched

Commit-side scheduler for the debug trace path. Takes the dual-issue core's two writeback commit slots (slot0 older than slot1) and converts them into a single in-order stream of one trace entry per cycle. It drops commits that do not write a register and holds the core through a stall handshake when the downstream trace write port cannot keep up. It sits between the core writeback stage and the trace FIFO, and replaces direct dual-port writes into that FIFO.

## Interface
Parameters:
- PC_W, 32, commit PC width
- DATA_W, 32, register write data width
- REG_W, 5, architectural register index width
- CNT_W, 32, emitted-entry counter width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmt0_valid  in  1  slot0 commit valid
- cmt0_wen  in  1  slot0 writes a register
- cmt0_pc  in  PC_W  slot0 PC
- cmt0_wnum  in  REG_W  slot0 destination register
- cmt0_wdata  in  DATA_W  slot0 write data
- cmt1_valid, cmt1_wen, cmt1_pc, cmt1_wnum, cmt1_wdata  in  1/1/PC_W/REG_W/DATA_W  slot1, same meaning as slot0
- cmt_ready  out  1  commit pair accepted this cycle; the core must hold all cmt* inputs stable while low
- cmt_stall  out  1  equals ~cmt_ready, routed to the core pipeline stall
- tr_valid  out  1  trace entry presented
- tr_ready  in  1  downstream accepts the entry
- tr_pc  out  PC_W  entry PC
- tr_wnum  out  REG_W  entry register index
- tr_wdata  out  DATA_W  entry write data
- tr_wen  out  4  byte enables; 4'hF whenever tr_valid is high, 4'h0 otherwise
- emit_cnt  out  CNT_W  count of entries handed off (tr_valid & tr_ready)

## Operation
- Qualification: a slot is *qualified* when valid & wen. Unqualified slots are consumed silently.
- Storage: a 2-entry in-order queue, q0 (head) and q1. FSM states: EMPTY, ONE, TWO (occupancy).
- cmt_ready = ~reset & (state==EMPTY | (state==ONE & tr_ready)). This is combinational from tr_ready. In TWO, cmt_ready is 0.
- Accept (cmt_ready=1): qualified slots are appended in order, slot0 first then slot1. Zero, one or two entries are appended. A lone qualified slot1 (slot0 invalid) is legal and is appended alone.
- Pop: when tr_valid & tr_ready, q1 shifts to q0.
- Transitions, with n = qualified count and p = pop:
  - EMPTY: n=0 stays EMPTY; n=1 goes to ONE; n=2 goes to TWO.
  - ONE: accept only when p=1. Then n=0 goes to EMPTY, n=1 stays ONE, n=2 goes to TWO. When p=0, stays ONE.
  - TWO: p=1 goes to ONE; p=0 stays TWO.
- Outputs: tr_valid = (state!=EMPTY), and tr_* = q0. tr_* are zero in EMPTY.
- emit_cnt increments by 1 per pop and wraps modulo 2^CNT_W.
- Ordering: entry order always equals program order (slot0 before slot1, earlier cycles first).

## Timing
- Reset: state EMPTY; tr_valid 0; tr_pc/tr_wnum/tr_wdata 0; tr_wen 0; emit_cnt 0; cmt_ready 0 during reset.
- Latency: an entry accepted in cycle t appears on tr_* at t+1 if the queue was empty.
- Throughput: one entry per cycle sustained with tr_ready tied high.
- A dual qualified commit stalls the core for exactly one cycle: the queue goes to TWO, then ONE with cmt_ready high again.
- Simultaneous accept and pop in ONE is legal and does not lose the popped entry.
- tr_* remain stable while tr_valid & ~tr_ready.
- Reset mid-operation discards queued entries with no further output, and emit_cnt returns to 0.

## Configuration
- TRACE_FILTER_R0_EN defined: qualification additionally requires wnum != 0, so writes to r0 never reach the trace.
- TRACE_FILTER_R0_EN undefined: r0 writes are emitted like any other register write.

## Structure
- Shared package trace_pkg holds:
  - the trace entry struct {pc, wdata, wnum}
  - the PC_W/DATA_W/REG_W defaults
  - the FSM state enum (EMPTY/ONE/TWO)
- One sub-module, trace_slot_qualify: combinational per-slot valid/wen/r0 filter, instantiated twice.

## Test plan
- Single slot0 commit {pc=0xBFC00000, wnum=2, wdata=0x1234}, tr_ready=1 -> next cycle tr_valid=1 with those values and tr_wen=4'hF; emit_cnt=1.
- Dual qualified commit pc0=0x100 and pc1=0x104, tr_ready=1 -> 0x100 then 0x104 on consecutive cycles; cmt_ready low exactly one cycle.
- tr_ready=0 for 5 cycles after a dual commit -> state TWO, cmt_ready=0 throughout, tr_pc held at 0x100; release -> 0x100 then 0x104, no loss or duplication.
- Slot0 wen=0 with slot1 qualified at 0x204 -> only 0x204 emitted. Slot1 wnum=0 -> dropped with TRACE_FILTER_R0_EN, emitted without it.
- Reset asserted while in TWO -> next cycle tr_valid=0, emit_cnt=0, and cmt_ready=1 once reset deasserts.
- Random mix of 10k commit pairs with random tr_ready -> scoreboard confirms program-order match, and emit_cnt equals the qualified-commit count modulo 2^32.
